uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter (FPGA_SERIAL_TX path, 9600 baud) among NUM_REQ byte

---
 rtl/uart_tx_arbiter_pkg.sv | 19 +
 rtl/uart_tx_arbiter_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 124 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM state encoding and a
// modular-increment helper used by the rotate-priority picker.
package uart_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } arb_state_e;

    // (idx + off) mod n, for small non-negative operands
    function automatic int unsigned wrap_add(input int unsigned idx, input int unsigned off,
                                             input int unsigned n);
        return (idx + off) % n;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotate-priority picker: scans last_grant+1, +2, ... mod NUM_REQ
// and returns the first asserted request.
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned GNT_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GNT_W-1:0]   last_grant,
    output logic [GNT_W-1:0]   winner,
    output logic               any_valid
);

    // Walk offsets from farthest to nearest so the nearest valid request wins.
    always_comb begin
        logic [GNT_W-1:0] idx;
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = GNT_W'(wrap_add(int'(last_grant), off, NUM_REQ));
            if (req[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// One byte in flight at a time; start/busy handshake toward the transmitter.
// Optional packet lock: define UART_ARB_PKT_LOCK_EN to keep the grant across a
// packet (until req_last) with a LOCK_TIMEOUT cycle release.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    localparam int unsigned GNT_W       = $clog2(NUM_REQ)
) (
    input  logic                      USER_CLK,
    input  logic                      FPGA_CPU_RESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [GNT_W-1:0]          grant_id,
    output logic                      arb_busy
);

    arb_state_e       state;
    logic [GNT_W-1:0] winner;
    logic             any_valid;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GNT_W   (GNT_W)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (grant_id),
        .winner     (winner),
        .any_valid  (any_valid)
    );

    assign arb_busy = (state != ST_IDLE);

`ifdef UART_ARB_PKT_LOCK_EN
    localparam int unsigned TIMER_W = $clog2(LOCK_TIMEOUT + 1);
    logic [TIMER_W-1:0] timer;
    logic               last_q;
`else
    // Packet lock compiled out: last flags and timeout have no effect.
    logic unused_cfg;
    assign unused_cfg = ^{req_last, LOCK_TIMEOUT[0]};
`endif

    // Arbitration FSM with registered handshake outputs.
    always_ff @(posedge USER_CLK) begin
        if (FPGA_CPU_RESET) begin
            state     <= ST_IDLE;
            req_ready <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            grant_id  <= GNT_W'(NUM_REQ - 1);
`ifdef UART_ARB_PKT_LOCK_EN
            timer     <= '0;
            last_q    <= 1'b1;
`endif
        end else begin
            tx_start  <= 1'b0;
            req_ready <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        grant_id  <= winner;
                        tx_data   <= req_data[winner*DATA_W +: DATA_W];
                        tx_start  <= 1'b1;
                        req_ready <= NUM_REQ'(1) << winner;
`ifdef UART_ARB_PKT_LOCK_EN
                        last_q    <= req_last[winner];
`endif
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // tx_busy seen during the issue cycle is not an acknowledge.
                    state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
`ifdef UART_ARB_PKT_LOCK_EN
                        state <= last_q ? ST_IDLE : ST_HOLD;
                        timer <= '0;
`else
                        state <= ST_IDLE;
`endif
                    end
                end
`ifdef UART_ARB_PKT_LOCK_EN
                ST_HOLD: begin
                    // Only the locked requester may continue its packet.
                    if (req_valid[grant_id]) begin
                        tx_data   <= req_data[grant_id*DATA_W +: DATA_W];
                        tx_start  <= 1'b1;
                        req_ready <= NUM_REQ'(1) << grant_id;
                        last_q    <= req_last[grant_id];
                        timer     <= '0;
                        state     <= ST_ISSUE;
                    end else if (timer == TIMER_W'(LOCK_TIMEOUT)) begin
                        timer <= '0;
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues drive the DUT, expected
// grants are queued by each test, and a monitor checks every tx_start.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned GNT_W   = 2;
`ifdef UART_ARB_PKT_LOCK_EN
    localparam int unsigned LT = 16;
`else
    localparam int unsigned LT = 65535;
`endif

    logic                      USER_CLK = 1'b0;
    logic                      FPGA_CPU_RESET = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_last = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_busy = 1'b0;
    logic [GNT_W-1:0]          grant_id;
    logic                      arb_busy;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_W       (DATA_W),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .USER_CLK       (USER_CLK),
        .FPGA_CPU_RESET (FPGA_CPU_RESET),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .tx_start       (tx_start),
        .tx_data        (tx_data),
        .tx_busy        (tx_busy),
        .grant_id       (grant_id),
        .arb_busy       (arb_busy)
    );

    always #5 USER_CLK = ~USER_CLK;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } byte_t;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    byte_t rq0[$];
    byte_t rq1[$];
    byte_t rq2[$];
    byte_t rq3[$];
    exp_t  expq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int vcyc[NUM_REQ];
    bit chk_lat = 1'b0;
    int dly = 0;
    int run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int id, input logic [7:0] d, input logic l);
        byte_t b;
        exp_t  e;
        b.data = d;
        b.last = l;
        e.id   = 2'(id);
        e.data = d;
        case (id)
            0: rq0.push_back(b);
            1: rq1.push_back(b);
            2: rq2.push_back(b);
            default: rq3.push_back(b);
        endcase
        expq.push_back(e);
    endtask

    always @(posedge USER_CLK) cyc <= cyc + 1;

    // Behavioural transmitter: busy rises 2 cycles after tx_start and lasts 20 cycles.
    always @(posedge USER_CLK) begin
        if (tx_start) begin
            dly <= 2;
        end else if (dly > 0) begin
            dly <= dly - 1;
            if (dly == 1) begin
                tx_busy <= 1'b1;
                run     <= 20;
            end
        end else if (run > 0) begin
            run <= run - 1;
            if (run == 1) tx_busy <= 1'b0;
        end
    end

    // Requester driver: pop on the ready strobe, present the next queued byte.
    task automatic drive_one(input int i, inout byte_t q[$]);
        if (req_ready[i] && q.size() > 0) void'(q.pop_front());
        if (q.size() > 0) begin
            if (!req_valid[i]) vcyc[i] = cyc;
            req_valid[i]               = 1'b1;
            req_data[i*DATA_W +: DATA_W] = q[0].data;
            req_last[i]                = q[0].last;
        end else begin
            req_valid[i] = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(negedge USER_CLK);
            drive_one(0, rq0);
            drive_one(1, rq1);
            drive_one(2, rq2);
            drive_one(3, rq3);
        end
    end

    // Monitor: every tx_start must match the next expected grant.
    initial begin
        bit   inflight = 1'b0;
        logic busy_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge USER_CLK);
            if (busy_prev && !tx_busy) inflight = 1'b0;
            busy_prev = tx_busy;
            if (tx_start) begin
                check("one_in_flight", {31'd0, inflight}, 32'd0);
                inflight = 1'b1;
                if (expq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got id %0d data %0h expected none",
                             grant_id, tx_data);
                end else begin
                    e = expq.pop_front();
                    check("grant_id", 32'(grant_id), 32'(e.id));
                    check("tx_data", 32'(tx_data), 32'(e.data));
                    check("req_ready", 32'(req_ready), 32'(4'b0001 << e.id));
                    if (chk_lat) check("latency", cyc, vcyc[e.id] + 1);
                end
            end else if (req_ready != '0) begin
                check("ready_without_start", 32'(req_ready), 32'd0);
            end
        end
    end

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge USER_CLK);
            if (expq.size() == 0 && rq0.size() == 0 && rq1.size() == 0 && rq2.size() == 0 &&
                rq3.size() == 0 && !arb_busy && !tx_busy && dly == 0)
                done = 1'b1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
            expq.delete();
        end
    endtask

    task automatic do_reset();
        @(posedge USER_CLK);
        #2 FPGA_CPU_RESET = 1'b1;
        @(posedge USER_CLK);
        #1 FPGA_CPU_RESET = 1'b0;
        @(posedge USER_CLK);
        #2;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge USER_CLK);
        #1;
        check("rst_arb_busy", 32'(arb_busy), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd3);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        FPGA_CPU_RESET = 1'b0;
        @(posedge USER_CLK);
        #2;

        // Single requester, one-cycle grant latency
        chk_lat = 1'b1;
        push(0, 8'h61, 1'b1);
        wait_idle(300);
        chk_lat = 1'b0;

        // Fairness: all four continuously valid
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 4; i++) push(i, 8'hA0 + 8'(i), 1'b1);
        wait_idle(3000);

        // Wrap and skip: only 1 and 3 request, starting from grant_id=3
        do_reset();
        rq1.push_back('{data: 8'h11, last: 1'b1});
        rq1.push_back('{data: 8'h12, last: 1'b1});
        rq1.push_back('{data: 8'h13, last: 1'b1});
        rq3.push_back('{data: 8'h31, last: 1'b1});
        rq3.push_back('{data: 8'h32, last: 1'b1});
        expq.push_back('{id: 2'd1, data: 8'h11});
        expq.push_back('{id: 2'd3, data: 8'h31});
        expq.push_back('{id: 2'd1, data: 8'h12});
        expq.push_back('{id: 2'd3, data: 8'h32});
        expq.push_back('{id: 2'd1, data: 8'h13});
        wait_idle(3000);

        // Reset mid-byte
        do_reset();
        push(2, 8'h42, 1'b1);
        for (int k = 0; k < 100 && !tx_busy; k++) @(negedge USER_CLK);
        check("mid_busy_seen", 32'(tx_busy), 32'd1);
        @(posedge USER_CLK);
        #2 FPGA_CPU_RESET = 1'b1;
        @(posedge USER_CLK);
        #1;
        check("mid_rst_arb_busy", 32'(arb_busy), 32'd0);
        check("mid_rst_grant_id", 32'(grant_id), 32'd3);
        check("mid_rst_tx_start", 32'(tx_start), 32'd0);
        FPGA_CPU_RESET = 1'b0;
        wait_idle(300);
        @(posedge USER_CLK);
        #2;
        push(0, 8'h07, 1'b1);
        push(1, 8'h17, 1'b1);
        wait_idle(1000);

`ifdef UART_ARB_PKT_LOCK_EN
        // Packet lock holds the grant for req0's two-byte packet
        do_reset();
        push(0, 8'h55, 1'b0);
        push(0, 8'hAA, 1'b1);
        push(1, 8'h66, 1'b1);
        expq.delete();
        expq.push_back('{id: 2'd0, data: 8'h55});
        expq.push_back('{id: 2'd0, data: 8'hAA});
        expq.push_back('{id: 2'd1, data: 8'h66});
        wait_idle(2000);

        // Lock timeout releases to req1
        do_reset();
        push(0, 8'h5A, 1'b0);
        push(1, 8'h6B, 1'b1);
        begin
            int gap = 0;
            for (int k = 0; k < 100 && !tx_busy; k++) @(negedge USER_CLK);
            for (int k = 0; k < 100 && tx_busy; k++) @(negedge USER_CLK);
            for (int k = 0; k < 100 && !tx_start; k++) begin
                @(negedge USER_CLK);
                gap++;
            end
            check("hold_gap_in_range", {31'd0, (gap >= 16 && gap <= 24)}, 32'd1);
        end
        wait_idle(1000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
